mdr_sequencer: RTL and testbench

- FSM controller that sequences the shared iterative multiply/divide/square-root datapath; its result is selected by the quotient/product exit mux.
- Accepts one operation request and drives the load, step and final-correction strobes for the correct iteration count.
- Drives the registered op code that steers the exit mux, then reports completion or error.
- Sits between the top-level command interface and the MDR datapath registers.

---
 rtl/mdr_sequencer.sv | 151 +++++++++++++++
 tb/tb_mdr_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mdr_sequencer.sv
// rtl/mdr_sequencer.sv - sequencing FSM for the shared iterative multiply/divide/root datapath
//
// Optional feature macro: MDR_ABORT_EN (adds the abort input and abort transitions).
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   start         operation request, sampled only while ready=1
//   op            00 multiply, 01 divide, 10 square root, 11 invalid
//   abort         (MDR_ABORT_EN only) cancel the operation in LOAD/RUN/FIX
//   divisor_zero  datapath flag, sampled together with start
//   msb_aq        partial-remainder sign; consumed by the datapath during FIX
//   ready         idle, able to accept start
//   load_en       one-cycle operand load strobe
//   step_en       one datapath iteration per cycle
//   fix_en        one-cycle remainder-correction strobe (divide/root)
//   op_q          latched op code, exit-mux select
//   iter_cnt      current iteration index
//   done          one-cycle completion pulse
//   err           error status, valid with done, held until next accepted start

module mdr_sequencer #(
    parameter int N = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                op,
`ifdef MDR_ABORT_EN
    input  logic                      abort,
`endif
    input  logic                      divisor_zero,
    input  logic                      msb_aq,
    output logic                      ready,
    output logic                      load_en,
    output logic                      step_en,
    output logic                      fix_en,
    output logic [1:0]                op_q,
    output logic [$clog2(N+2)-1:0]    iter_cnt,
    output logic                      done,
    output logic                      err
);

    localparam int MUL_ITER  = N + 1;
    localparam int ROOT_ITER = (N + 2) / 2;
    localparam int CW        = $clog2(N + 2);

    localparam logic [CW-1:0] MUL_LAST  = CW'(MUL_ITER - 1);
    localparam logic [CW-1:0] ROOT_LAST = CW'(ROOT_ITER - 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_ROOT = 2'b10;
    localparam logic [1:0] OP_BAD  = 2'b11;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic          req_bad;
    logic          run_last;
    logic [CW-1:0] last_idx;
    logic          abort_hit;

    // The remainder correction itself lives in the datapath; the sequencer
    // only times the FIX cycle, so msb_aq is deliberately not consumed here.
    logic unused_msb_aq;
    assign unused_msb_aq = msb_aq;

    // Invalid op or divide-by-zero skips straight to DONE with err set.
    assign req_bad = (op == OP_BAD) || ((op == OP_DIV) && divisor_zero);

    assign last_idx = (op_q == OP_ROOT) ? ROOT_LAST : MUL_LAST;
    assign run_last = (iter_cnt == last_idx);

`ifdef MDR_ABORT_EN
    assign abort_hit = abort && ((state == S_LOAD) || (state == S_RUN) || (state == S_FIX));
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = req_bad ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: state_nx = S_RUN;
            S_RUN: begin
                if (run_last) begin
                    state_nx = (op_q == OP_MUL) ? S_DONE : S_FIX;
                end
            end
            S_FIX:  state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nx = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            op_q     <= OP_MUL;
            err      <= 1'b0;
            iter_cnt <= '0;
        end else begin
            state <= state_nx;
            if (abort_hit) begin
                err      <= 1'b0;
                iter_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            op_q <= op;
                            err  <= req_bad;
                            // Clear on entry so LOAD already shows index 0;
                            // the error path leaves the old index untouched.
                            if (!req_bad) begin
                                iter_cnt <= '0;
                            end
                        end
                    end
                    S_RUN: begin
                        if (!run_last) begin
                            iter_cnt <= iter_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Strobes decode from the registered state only.
    assign ready   = (state == S_IDLE);
    assign load_en = (state == S_LOAD);
    assign step_en = (state == S_RUN);
    assign fix_en  = (state == S_FIX);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_mdr_sequencer.sv
// tb/tb_mdr_sequencer.sv - directed self-checking bench for mdr_sequencer

module tb_mdr_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic       divisor_zero;
    logic       msb_aq;
    logic       ready;
    logic       load_en;
    logic       step_en;
    logic       fix_en;
    logic [1:0] op_q;
    logic [2:0] iter_cnt;
    logic       done;
    logic       err;
`ifdef MDR_ABORT_EN
    logic       abort;
`endif

    int vectors;
    int miscompares;

    // flag bundle order: {ready, load_en, step_en, fix_en, done}
    localparam logic [4:0] F_IDLE = 5'b10000;
    localparam logic [4:0] F_LOAD = 5'b01000;
    localparam logic [4:0] F_RUN  = 5'b00100;
    localparam logic [4:0] F_FIX  = 5'b00010;
    localparam logic [4:0] F_DONE = 5'b00001;

    mdr_sequencer #(.N(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
`ifdef MDR_ABORT_EN
        .abort        (abort),
`endif
        .divisor_zero (divisor_zero),
        .msb_aq       (msb_aq),
        .ready        (ready),
        .load_en      (load_en),
        .step_en      (step_en),
        .fix_en       (fix_en),
        .op_q         (op_q),
        .iter_cnt     (iter_cnt),
        .done         (done),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the current cycle, then advance to the next negedge.
    task automatic cyc(input string tag, input logic [4:0] f, input logic [2:0] it);
        chk({tag, ".flags"}, {27'd0, ready, load_en, step_en, fix_en, done}, {27'd0, f});
        chk({tag, ".iter"}, {29'd0, iter_cnt}, {29'd0, it});
        @(negedge clk);
    endtask

    // Present a request for one edge; returns at the negedge of cycle 1.
    task automatic start_op(input logic [1:0] o, input logic dz);
        start = 1'b1;
        op = o;
        divisor_zero = dz;
        @(negedge clk);
        start = 1'b0;
        op = 2'b00;
        divisor_zero = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        divisor_zero = 1'b0;
        msb_aq = 1'b0;
`ifdef MDR_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("reset.flags", {27'd0, ready, load_en, step_en, fix_en, done}, {27'd0, F_IDLE});
        chk("reset.op_q", {30'd0, op_q}, 32'd0);
        chk("reset.err", {31'd0, err}, 32'd0);
        chk("reset.iter", {29'd0, iter_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc("idle0", F_IDLE, 3'd0);

        // Multiply: LOAD t+1, RUN t+2..t+6 (iter 0..4), DONE t+7
        start_op(2'b00, 1'b0);
        cyc("mul.load", F_LOAD, 3'd0);
        for (int i = 0; i < 5; i++) cyc("mul.run", F_RUN, 3'(i));
        chk("mul.op_q", {30'd0, op_q}, 32'd0);
        chk("mul.err", {31'd0, err}, 32'd0);
        cyc("mul.done", F_DONE, 3'd4);
        cyc("mul.idle", F_IDLE, 3'd4);

        // Divide with a stray start mid-RUN and divisor_zero toggled after acceptance
        start_op(2'b01, 1'b0);
        cyc("div.load", F_LOAD, 3'd0);
        divisor_zero = 1'b1;
        cyc("div.run", F_RUN, 3'd0);
        start = 1'b1;
        op = 2'b11;
        cyc("div.run", F_RUN, 3'd1);
        start = 1'b0;
        op = 2'b00;
        divisor_zero = 1'b0;
        for (int i = 2; i < 5; i++) cyc("div.run", F_RUN, 3'(i));
        msb_aq = 1'b1;
        cyc("div.fix", F_FIX, 3'd4);
        msb_aq = 1'b0;
        chk("div.op_q", {30'd0, op_q}, 32'd1);
        chk("div.err", {31'd0, err}, 32'd0);
        cyc("div.done", F_DONE, 3'd4);
        cyc("div.idle", F_IDLE, 3'd4);

        // Square root: RUN t+2..t+4 (iter 0..2), FIX t+5, DONE t+6
        start_op(2'b10, 1'b0);
        cyc("root.load", F_LOAD, 3'd0);
        for (int i = 0; i < 3; i++) cyc("root.run", F_RUN, 3'(i));
        cyc("root.fix", F_FIX, 3'd2);
        chk("root.op_q", {30'd0, op_q}, 32'd2);
        cyc("root.done", F_DONE, 3'd2);
        cyc("root.idle", F_IDLE, 3'd2);

        // Invalid op: DONE at t+1 with err, iter_cnt untouched
        start_op(2'b11, 1'b0);
        chk("bad.op_q", {30'd0, op_q}, 32'd3);
        chk("bad.err", {31'd0, err}, 32'd1);
        cyc("bad.done", F_DONE, 3'd2);
        chk("bad.err_hold", {31'd0, err}, 32'd1);
        cyc("bad.idle", F_IDLE, 3'd2);

        // Divide by zero: same error path
        start_op(2'b01, 1'b1);
        chk("dz.op_q", {30'd0, op_q}, 32'd1);
        chk("dz.err", {31'd0, err}, 32'd1);
        cyc("dz.done", F_DONE, 3'd2);
        cyc("dz.idle", F_IDLE, 3'd2);

        // Valid multiply clears err on acceptance
        start_op(2'b00, 1'b0);
        chk("clr.err", {31'd0, err}, 32'd0);
        cyc("clr.load", F_LOAD, 3'd0);
        for (int i = 0; i < 5; i++) cyc("clr.run", F_RUN, 3'(i));
        chk("clr.op_q", {30'd0, op_q}, 32'd0);
        cyc("clr.done", F_DONE, 3'd4);
        cyc("clr.idle", F_IDLE, 3'd4);

        // Asynchronous reset mid-RUN
        start_op(2'b01, 1'b0);
        cyc("rrun.load", F_LOAD, 3'd0);
        cyc("rrun.run", F_RUN, 3'd0);
        cyc("rrun.run", F_RUN, 3'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rrun.flags", {27'd0, ready, load_en, step_en, fix_en, done}, {27'd0, F_IDLE});
        chk("rrun.iter", {29'd0, iter_cnt}, 32'd0);
        chk("rrun.op_q", {30'd0, op_q}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc("rrun.hold", F_IDLE, 3'd0);
        rst = 1'b0;
        cyc("rrun.rel", F_IDLE, 3'd0);
        start_op(2'b10, 1'b0);
        cyc("rrun.load2", F_LOAD, 3'd0);
        for (int i = 0; i < 3; i++) cyc("rrun.run2", F_RUN, 3'(i));
        cyc("rrun.fix2", F_FIX, 3'd2);
        chk("rrun.op_q2", {30'd0, op_q}, 32'd2);
        cyc("rrun.done2", F_DONE, 3'd2);
        cyc("rrun.idle2", F_IDLE, 3'd2);

`ifdef MDR_ABORT_EN
        // Abort at iteration 2 of a divide
        start_op(2'b01, 1'b0);
        cyc("abt.load", F_LOAD, 3'd0);
        cyc("abt.run", F_RUN, 3'd0);
        cyc("abt.run", F_RUN, 3'd1);
        abort = 1'b1;
        cyc("abt.run", F_RUN, 3'd2);
        abort = 1'b0;
        chk("abt.op_q", {30'd0, op_q}, 32'd1);
        chk("abt.err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 4; i++) cyc("abt.idle", F_IDLE, 3'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
